tiny_nn_seq: RTL and testbench

Job sequencer placed in front of `tiny_nn_top`. It accepts a stream of 16-bit command words over a valid/ready handshake and issues them to the core one per cycle. After the last word it drives NOP words until the core reports idle, with a timeout. Every core output byte produced during a job is forwarded as a result stream, so software and benches see one framed job instead of raw per-cycle I/O.

---
 rtl/tiny_nn_seq_pkg.sv | 28 ++
 rtl/tiny_nn_seq_timeout.sv | 30 +++
 rtl/tiny_nn_seq.sv | 147 ++++++++++++++
 tb/tb_tiny_nn_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_nn_seq_pkg.sv
// Shared types and constants for the tiny_nn job sequencer.
package tiny_nn_seq_pkg;

   localparam int unsigned CmdW = 16;
   localparam int unsigned OutW = 8;
   localparam int unsigned LenW = 16;
   localparam int unsigned ToW  = 16;

   localparam logic [CmdW-1:0] CmdNop = 16'h0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic            last;
      logic [CmdW-1:0] data;
   } seq_cmd_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [LenW-1:0] sat_inc(input logic [LenW-1:0] v);
      return (v == '1) ? v : v + LenW'(1);
   endfunction

endpackage

// File: rtl/tiny_nn_seq_timeout.sv
// Drain watchdog: counts enabled cycles, flags the cycle whose increment reaches TimeoutCycles.
module tiny_nn_seq_timeout
   import tiny_nn_seq_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 100
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_c
);

   localparam logic [ToW-1:0] HitVal = ToW'(TimeoutCycles - 1);

   logic [ToW-1:0] count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + ToW'(1);
      end
   end

   assign hit_c = en_i && (count_q == HitVal);

endmodule

// File: rtl/tiny_nn_seq.sv
// Job sequencer in front of tiny_nn_top: streams command words to the core,
// drains with NOPs until the core idles (or times out), and forwards core output bytes.
module tiny_nn_seq
   import tiny_nn_seq_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 100
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic [CmdW-1:0] cmd_data_i,
   input  logic            cmd_last_i,
   output logic [CmdW-1:0] core_data_o,
   input  logic [OutW-1:0] core_data_i,
   input  logic            core_idle_i,
   output logic            result_valid_o,
   output logic [OutW-1:0] result_data_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            timeout_o,
   output logic            underrun_o,
   output logic [LenW-1:0] job_len_o
);

   seq_state_e state_q, state_d;
   seq_cmd_t   cmd_c;
   logic       accept_c;
   logic       to_clr_c, to_en_c, to_hit_c;

   logic            cmd_ready_q, cmd_ready_d;
   logic [CmdW-1:0] core_data_q, core_data_d;
   logic            result_valid_q, result_valid_d;
   logic [OutW-1:0] result_data_q, result_data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            timeout_q, timeout_d;
   logic            underrun_q, underrun_d;
   logic [LenW-1:0] job_len_q, job_len_d;

   assign cmd_c    = '{last: cmd_last_i, data: cmd_data_i};
   assign accept_c = cmd_valid_i && cmd_ready_q;

   // Counter is held at zero outside DRAIN, so every drain starts from zero.
   assign to_clr_c = (state_q != DRAIN);
   assign to_en_c  = (state_q == DRAIN) && !core_idle_i;

   tiny_nn_seq_timeout #(
      .TimeoutCycles(TimeoutCycles)
   ) u_timeout (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .clr_i (to_clr_c),
      .en_i  (to_en_c),
      .hit_c (to_hit_c)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = cmd_c.last ? DRAIN : STREAM;
         STREAM:  if (accept_c && cmd_c.last) state_d = DRAIN;
         DRAIN:   if (core_idle_i || to_hit_c) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next values; ready/busy/done follow the upcoming state so they line up with it.
   always_comb begin
      cmd_ready_d    = (state_d == IDLE) || (state_d == STREAM);
      core_data_d    = accept_c ? cmd_c.data : CmdNop;
      busy_d         = (state_d != IDLE);
      done_d         = (state_d == DONE);
      result_valid_d = (state_q == STREAM) || (state_q == DRAIN);
      result_data_d  = result_valid_d ? core_data_i : result_data_q;
      timeout_d      = timeout_q;
      underrun_d     = underrun_q;
      job_len_d      = job_len_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               timeout_d  = 1'b0;
               underrun_d = 1'b0;
               job_len_d  = LenW'(1);
            end
         end
         STREAM: begin
            if (accept_c) begin
               job_len_d = sat_inc(job_len_q);
            end else if (!cmd_valid_i) begin
               underrun_d = 1'b1;
            end
         end
         DRAIN: begin
            if (to_hit_c) timeout_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_ready_q    <= 1'b0;
         core_data_q    <= CmdNop;
         result_valid_q <= 1'b0;
         result_data_q  <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         timeout_q      <= 1'b0;
         underrun_q     <= 1'b0;
         job_len_q      <= '0;
      end else begin
         cmd_ready_q    <= cmd_ready_d;
         core_data_q    <= core_data_d;
         result_valid_q <= result_valid_d;
         result_data_q  <= result_data_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         timeout_q      <= timeout_d;
         underrun_q     <= underrun_d;
         job_len_q      <= job_len_d;
      end
   end

   assign cmd_ready_o    = cmd_ready_q;
   assign core_data_o    = core_data_q;
   assign result_valid_o = result_valid_q;
   assign result_data_o  = result_data_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign timeout_o      = timeout_q;
   assign underrun_o     = underrun_q;
   assign job_len_o      = job_len_q;

endmodule

// File: tb/tb_tiny_nn_seq.sv
// Self-checking bench for tiny_nn_seq: job table plus reset-in-drain sequence, result scoreboard.
module tb_tiny_nn_seq;

   localparam int unsigned TO = 100;

   logic        clk;
   logic        rst_ni;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [15:0] cmd_data_i;
   logic        cmd_last_i;
   logic [15:0] core_data_o;
   logic [7:0]  core_data_i;
   logic        core_idle_i;
   logic        result_valid_o;
   logic [7:0]  result_data_o;
   logic        busy_o;
   logic        done_o;
   logic        timeout_o;
   logic        underrun_o;
   logic [15:0] job_len_o;

   tiny_nn_seq #(.TimeoutCycles(TO)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_data_i    (cmd_data_i),
      .cmd_last_i    (cmd_last_i),
      .core_data_o   (core_data_o),
      .core_data_i   (core_data_i),
      .core_idle_i   (core_idle_i),
      .result_valid_o(result_valid_o),
      .result_data_o (result_data_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .timeout_o     (timeout_o),
      .underrun_o    (underrun_o),
      .job_len_o     (job_len_o)
   );

   // Stand-in core: output byte is a fixed scramble of the word it is being fed.
   function automatic logic [7:0] core_f(input logic [15:0] x);
      return x[7:0] ^ x[15:8] ^ 8'hA5;
   endfunction
   assign core_data_i = core_f(core_data_o);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int              n;
      logic [3:0][15:0] w;
      int              gap;      // insert one invalid cycle after this word index (-1: none)
      int              idle_at;  // first drain cycle on which the core reports idle
      bit              hold;     // keep valid high through drain/done with next job's first word
      logic [15:0]     exp_len;
      bit              exp_to;
      bit              exp_ur;
      int              exp_res;
   } job_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          res_cnt  = 0;
   logic [7:0]  exp_q[$];
   job_t        tbl[7];

   function automatic job_t mk(input int n, input logic [3:0][15:0] w, input int gap,
                               input int idle_at, input bit hold, input logic [15:0] exp_len,
                               input bit exp_to, input bit exp_ur, input int exp_res);
      job_t j;
      j.n = n; j.w = w; j.gap = gap; j.idle_at = idle_at; j.hold = hold;
      j.exp_len = exp_len; j.exp_to = exp_to; j.exp_ur = exp_ur; j.exp_res = exp_res;
      return j;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Advance one cycle; result stream is scored at the falling edge.
   task automatic step();
      @(negedge clk);
      if (result_valid_o) begin
         res_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL result_unexpected: got 0x%0h, want no result (t=%0t)", result_data_o, $time);
         end else begin
            check("result_data", 32'(result_data_o), 32'(exp_q.pop_front()));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input job_t j, input logic [15:0] next_first, input int abort_at);
      int          d_exp;
      bit          bad;
      logic [15:0] w;
      res_cnt     = 0;
      d_exp       = (j.idle_at < int'(TO)) ? j.idle_at : int'(TO);
      core_idle_i = (j.idle_at == 1);
      for (int k = 0; k < 20 && !cmd_ready_o; k++) step();
      check("ready_start", 32'(cmd_ready_o), 32'(1));
      for (int i = 0; i < j.n; i++) begin
         w           = j.w[i];
         cmd_valid_i = 1'b1;
         cmd_data_i  = w;
         cmd_last_i  = (i == j.n - 1);
         exp_q.push_back(core_f(w));
         step();
         check("issue_word", 32'(core_data_o), 32'(w));
         if (i == j.gap) begin
            cmd_valid_i = 1'b0;
            cmd_data_i  = 16'hFFFF;
            cmd_last_i  = 1'b1;
            exp_q.push_back(core_f(16'h0000));
            step();
            check("gap_nop", 32'(core_data_o), 32'(0));
         end
      end
      for (int k = 1; k < d_exp; k++) exp_q.push_back(core_f(16'h0000));
      cmd_valid_i = j.hold;
      cmd_data_i  = next_first;
      cmd_last_i  = 1'b0;
      bad = 1'b0;
      for (int drain = 1; drain <= d_exp; drain++) begin
         core_idle_i = (drain >= j.idle_at);
         if (drain == abort_at) begin
            rst_ni = 1'b0;
            return;
         end
         if (done_o || cmd_ready_o || !busy_o || (drain > 1 && core_data_o != 16'h0000)) bad = 1'b1;
         step();
      end
      check("drain_quiet", 32'(bad), 32'(0));
      check("done_pulse", 32'(done_o), 32'(1));
      check("ready_in_done", 32'(cmd_ready_o), 32'(0));
      check("job_len", 32'(job_len_o), 32'(j.exp_len));
      check("timeout", 32'(timeout_o), 32'(j.exp_to));
      check("underrun", 32'(underrun_o), 32'(j.exp_ur));
      step();
      check("done_cleared", 32'(done_o), 32'(0));
      check("ready_after_done", 32'(cmd_ready_o), 32'(1));
      check("busy_after_done", 32'(busy_o), 32'(0));
      check("result_count", 32'(res_cnt), 32'(j.exp_res));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(cmd_ready_o), 32'(0));
      check({tag, "_core_data"}, 32'(core_data_o), 32'(0));
      check({tag, "_res_valid"}, 32'(result_valid_o), 32'(0));
      check({tag, "_res_data"}, 32'(result_data_o), 32'(0));
      check({tag, "_busy"}, 32'(busy_o), 32'(0));
      check({tag, "_done"}, 32'(done_o), 32'(0));
      check({tag, "_timeout"}, 32'(timeout_o), 32'(0));
      check({tag, "_underrun"}, 32'(underrun_o), 32'(0));
      check({tag, "_job_len"}, 32'(job_len_o), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] nf;
      job_t        jr;
      //            n  words (w3..w0)                                   gap idle hold len to ur res
      tbl[0] = mk(4, {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, -1,    3, 0,  4, 0, 0,   6);
      tbl[1] = mk(1, {16'h0000, 16'h0000, 16'h0000, 16'h00C3}, -1,    1, 0,  1, 0, 0,   1);
      tbl[2] = mk(2, {16'h0000, 16'h0000, 16'h2222, 16'h1111}, -1, 1000, 0,  2, 1, 0, 101);
      tbl[3] = mk(4, {16'hD4D4, 16'hC3C3, 16'hB2B2, 16'hA1A1},  1,    2, 0,  4, 0, 1,   6);
      tbl[4] = mk(3, {16'h0000, 16'h0506, 16'h0304, 16'h0102}, -1,    2, 1,  3, 0, 0,   4);
      tbl[5] = mk(2, {16'h0000, 16'h0000, 16'hF0F0, 16'h0F0F}, -1,    1, 1,  2, 0, 0,   2);
      tbl[6] = mk(1, {16'h0000, 16'h0000, 16'h0000, 16'h7777}, -1,    4, 0,  1, 0, 0,   4);

      rst_ni      = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_data_i  = 16'h0000;
      cmd_last_i  = 1'b0;
      core_idle_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      #2 rst_ni = 1'b1;
      step();
      check("ready_idle", 32'(cmd_ready_o), 32'(1));
      check("busy_idle", 32'(busy_o), 32'(0));

      for (int t = 0; t < 7; t++) begin
         nf = (t < 6) ? tbl[t + 1].w[0] : 16'h0000;
         run_job(tbl[t], nf, 0);
      end

      // Reset asserted in the third drain cycle of a never-idling job.
      jr = mk(2, {16'h0000, 16'h0000, 16'h1357, 16'h4242}, -1, 1000, 0, 2, 0, 0, 0);
      run_job(jr, 16'h0000, 3);
      #2;
      check_reset_outputs("async_rst");
      exp_q.delete();
      cmd_valid_i = 1'b0;
      core_idle_i = 1'b1;
      step();
      check("rst_held_done", 32'(done_o), 32'(0));
      #3 rst_ni = 1'b1;
      step();
      check("ready_after_rst", 32'(cmd_ready_o), 32'(1));
      jr = mk(3, {16'h0000, 16'h6060, 16'h5050, 16'h4040}, -1, 2, 0, 3, 0, 0, 4);
      run_job(jr, 16'h0000, 0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
